// File: rtl/mult_div_pkg.sv
// Shared control encodings for the multiply/divide unit: operation codes and FSM states.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic isDivide(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle on magnitudes.
// Handshake: start is a request with no ready, sampled only in IDLE/DONE; done pulses one cycle with hi/lo valid.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_e           dbgState
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  op_e                curOp;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   operand;
  logic               negLo;
  logic               negHi;

  op_e                opIn;
  logic               signedIn;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;

  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] stepNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   finalHi;
  logic [WIDTH-1:0]   finalLo;

  assign dbgState = state;
  assign opIn     = op_e'(op);
  assign signedIn = isSignedOp(opIn);
  assign absA     = (signedIn && a[WIDTH-1]) ? -a : a;
  assign absB     = (signedIn && b[WIDTH-1]) ? -b : b;

  // Multiply keeps the multiplier in the low half and accumulates into the high half;
  // divide keeps the partial remainder high and shifts quotient bits in at the bottom.
  always_comb begin
    addSum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
    trial  = work[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    if (isDivide(curOp)) begin
      stepNext = trial[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end else begin
      stepNext = {addSum, work[WIDTH-1:1]};
    end
  end

  always_comb begin
    prodFix = negLo ? -stepNext : stepNext;
    quotFix = negLo ? -stepNext[WIDTH-1:0] : stepNext[WIDTH-1:0];
    remFix  = negHi ? -stepNext[2*WIDTH-1:WIDTH] : stepNext[2*WIDTH-1:WIDTH];
    if (isDivide(curOp)) begin
      finalHi = remFix;
      finalLo = quotFix;
    end else begin
      finalHi = prodFix[2*WIDTH-1:WIDTH];
      finalLo = prodFix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      work     <= '0;
      operand  <= '0;
      curOp    <= OP_MULT;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            curOp <= opIn;
            count <= LAST;
            if (isDivide(opIn) && (b == '0)) begin
              // Divide by zero reports immediately and leaves hi/lo untouched.
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state   <= ST_RUN;
              busy    <= 1'b1;
              operand <= isDivide(opIn) ? absB : absA;
              work    <= isDivide(opIn) ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
              negLo   <= signedIn && (a[WIDTH-1] ^ b[WIDTH-1]);
              negHi   <= signedIn && a[WIDTH-1];
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          work <= stepNext;
          if (count == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= finalHi;
            lo    <= finalLo;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Bench for mult_div: per-cycle comparison against an arithmetic reference model plus literal pins.
module tb_mult_div;
  import mult_div_pkg::*;

  localparam int W  = 32;
  localparam int W8 = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, start8;
  logic [1:0]    op, op8;
  logic [W-1:0]  a, b;
  logic [W8-1:0] a8, b8;
  logic          busy, done, dz, busy8, done8, dz8;
  logic [W-1:0]  hi, lo;
  logic [W8-1:0] hi8, lo8;
  state_e        st, st8;

  mult_div #(.WIDTH(W)) u_dut (
    .clock(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(dz), .hi(hi), .lo(lo), .dbgState(st)
  );

  mult_div #(.WIDTH(W8)) u_dut8 (
    .clock(clk), .reset(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8), .dbgState(st8)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for any width up to 32: sign-extend, use native 64-bit math, truncate.
  function automatic void refOp(input int w, input logic [1:0] o, input logic [63:0] ain,
                                input logic [63:0] bin, output logic [63:0] rh,
                                output logic [63:0] rl, output logic rdz);
    logic [63:0] mask, av, bv, pu;
    longint sa, sb, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    av = ain & mask;
    bv = bin & mask;
    sa = av[w-1] ? (longint'(av) - (longint'(1) << w)) : longint'(av);
    sb = bv[w-1] ? (longint'(bv) - (longint'(1) << w)) : longint'(bv);
    rdz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sa * sb; rh = (64'(p) >> w) & mask; rl = 64'(p) & mask; end
      2'b01: begin pu = av * bv; rh = (pu >> w) & mask; rl = pu & mask; end
      2'b10: begin
        if (bv == 0) rdz = 1'b1;
        else begin q = sa / sb; r = sa % sb; rl = 64'(q) & mask; rh = 64'(r) & mask; end
      end
      default: begin
        if (bv == 0) rdz = 1'b1;
        else begin rl = av / bv; rh = av % bv; end
      end
    endcase
  endfunction

  // scoreboard: pending {hi,lo} results of the 32-bit instance
  logic [2*W-1:0] exp_q[$];
  logic           checkEn = 1'b0;
  int             mRun = 0;
  logic           expBusy = 1'b0, expDone = 1'b0, expDz = 1'b0;
  logic [W-1:0]   expHi = '0, expLo = '0;

  always @(posedge clk) begin
    logic [63:0] rh, rl;
    logic rdz;
    if (!rst) begin
      mRun = 0; expBusy = 1'b0; expDone = 1'b0; expDz = 1'b0;
      expHi = '0; expLo = '0;
      exp_q.delete();
      checkEn = 1'b1;
    end else begin
      expDone = 1'b0;
      expDz   = 1'b0;
      if (mRun > 0) begin
        mRun--;
        if (mRun == 0) begin
          expDone = 1'b1;
          {expHi, expLo} = exp_q.pop_front();
        end
      end else if (start) begin
        refOp(W, op, 64'(a), 64'(b), rh, rl, rdz);
        if (rdz) begin
          expDone = 1'b1;
          expDz   = 1'b1;
        end else begin
          mRun = W;
          exp_q.push_back({rh[W-1:0], rl[W-1:0]});
        end
      end
      expBusy = (mRun > 0);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("busy", 64'(busy), 64'(expBusy));
      check("done", 64'(done), 64'(expDone));
      check("div_zero", 64'(dz), 64'(expDz));
      check("hi", 64'(hi), 64'(expHi));
      check("lo", 64'(lo), 64'(expLo));
      check("state", 64'(st), expDone ? 64'(ST_DONE) : (expBusy ? 64'(ST_RUN) : 64'(ST_IDLE)));
    end
  end

  // driver: issue one op, scramble inputs afterwards, wait for done (bounded)
  task automatic runOp(input bit is8, input logic [1:0] o, input logic [63:0] av,
                       input logic [63:0] bv, output int n);
    if (is8) begin start8 = 1'b1; op8 = o; a8 = av[7:0]; b8 = bv[7:0]; end
    else begin start = 1'b1; op = o; a = av[31:0]; b = bv[31:0]; end
    @(negedge clk);
    if (is8) begin start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
    else begin start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; end
    n = 1;
    while (!(is8 ? done8 : done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(is8 ? done8 : done)) begin
      nChecks++;
      nErrors++;
      $display("FAIL timeout: no done after %0d cycles", n);
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = 32'h0;
      1: t = 32'hFFFFFFFF;
      2: t = 32'h80000000;
      3: t = 32'($urandom_range(0, 20));
      4: begin t = 32'($urandom_range(1, 20)); t = -t; end
      default: t = $urandom;
    endcase
    return t;
  endfunction

  initial begin
    int n, nExp;
    bit seen;
    logic [1:0] o;
    logic [63:0] av, bv, rh, rl;
    logic rdz;
    logic [7:0] held8Hi, held8Lo;

    rst = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    runOp(0, 2'b00, 64'hFFFFFFFD, 64'h5, n);
    check("mult latency", 64'(n), 64'd33);
    check("mult hi", 64'(hi), 64'hFFFFFFFF);
    check("mult lo", 64'(lo), 64'hFFFFFFF1);
    runOp(0, 2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF, n);
    check("multu hi", 64'(hi), 64'hFFFFFFFE);
    check("multu lo", 64'(lo), 64'h00000001);
    runOp(0, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, n);
    check("mult -1*-1 hi", 64'(hi), 64'h0);
    check("mult -1*-1 lo", 64'(lo), 64'h1);
    runOp(0, 2'b10, 64'hFFFFFFF9, 64'h2, n);
    check("div -7/2 lo", 64'(lo), 64'hFFFFFFFD);
    check("div -7/2 hi", 64'(hi), 64'hFFFFFFFF);
    runOp(0, 2'b10, 64'h80000000, 64'hFFFFFFFF, n);
    check("div ovf lo", 64'(lo), 64'h80000000);
    check("div ovf hi", 64'(hi), 64'h0);
    check("div ovf dz", 64'(dz), 64'h0);
    runOp(0, 2'b11, 64'h0000ABCD, 64'h00010000, n);
    check("divu rem hi", 64'(hi), 64'h0000ABCD);
    runOp(0, 2'b11, 64'h12345678, 64'h0, n);
    check("div0 latency", 64'(n), 64'd1);
    check("div0 flag", 64'(dz), 64'd1);
    check("div0 hi held", 64'(hi), 64'h0000ABCD);
    @(negedge clk);

    // start pulsed mid-RUN must be ignored
    start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 5) begin start = 1'b1; op = 2'b11; a = 32'h1; b = 32'h0; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("midrun latency", 64'(n), 64'd33);
    check("midrun lo", 64'(lo), 64'h06260060);
    check("midrun dz", 64'(dz), 64'd0);
    @(negedge clk);

    // reset in cycle 10 of a multiply
    start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    if (done) seen = 1'b1;
    check("reset abort no done", 64'(seen), 64'd0);
    check("reset abort busy", 64'(busy), 64'd0);
    check("reset abort lo", 64'(lo), 64'd0);
    rst = 1'b1;
    runOp(0, 2'b00, 64'd7, 64'd6, n);
    check("post-reset latency", 64'(n), 64'd33);
    check("post-reset lo", 64'(lo), 64'h2A);
    check("post-reset hi", 64'(hi), 64'h0);

    // randomized 32-bit traffic with back-to-back and idle gaps
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      av = 64'(pick());
      bv = 64'(pick());
      runOp(0, o, av, bv, n);
      nExp = (o[1] && bv == 0) ? 1 : W + 1;
      check("rand latency", 64'(n), 64'(nExp));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // 8-bit instance
    runOp(1, 2'b10, 64'hF9, 64'h02, n);
    check("div8 latency", 64'(n), 64'd9);
    check("div8 lo", 64'(lo8), 64'hFD);
    check("div8 hi", 64'(hi8), 64'hFF);
    runOp(1, 2'b11, 64'hC8, 64'h07, n);
    check("div8 b2b latency", 64'(n), 64'd9);
    check("div8 b2b lo", 64'(lo8), 64'h1C);
    check("div8 b2b hi", 64'(hi8), 64'h04);
    held8Hi = 8'h04;
    held8Lo = 8'h1C;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      av = 64'($urandom_range(0, 255));
      bv = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      refOp(W8, o, av, bv, rh, rl, rdz);
      runOp(1, o, av, bv, n);
      check("rand8 latency", 64'(n), rdz ? 64'd1 : 64'd9);
      check("rand8 dz", 64'(dz8), 64'(rdz));
      if (!rdz) begin held8Hi = rh[7:0]; held8Lo = rl[7:0]; end
      check("rand8 hi", 64'(hi8), 64'(held8Hi));
      check("rand8 lo", 64'(lo8), 64'(held8Lo));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; legal range 4..64.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clock edge).
REQ-004 SHALL have port start  input  1  request to begin an operation, sampled in IDLE or DONE only.
REQ-005 SHALL have port op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor, sampled with start.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port div_zero  output  1  high with done when a divide had b == 0.
REQ-011 SHALL have port hi  output  WIDTH  upper product half / remainder.
REQ-012 SHALL have port lo  output  WIDTH  lower product half / quotient.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH iterations, DONE->IDLE unless start, DONE->RUN on start (back-to-back).
REQ-014 SHALL, with start high in cycle 0, spend cycles 1..WIDTH in RUN and assert done in cycle WIDTH+1.
REQ-015 SHALL ignore start while in RUN; captured operands and op stay unchanged.
REQ-016 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle on magnitudes, using an iteration counter of $clog2(WIDTH) bits that counts down from WIDTH-1 to 0.
REQ-017 SHALL, for MULT/MULTU, make {hi,lo} the full 2*WIDTH-bit signed/unsigned product.
REQ-018 SHALL, for DIV/DIVU, set lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend (signed) or unsigned remainder.
REQ-019 SHALL, for signed DIV of most-negative by -1, produce lo = most-negative value, hi = 0, div_zero = 0.
REQ-020 SHALL apply sign correction when leaving RUN so hi/lo are registered and valid in the done cycle.
REQ-021 SHALL, for DIV/DIVU with b == 0, skip RUN, enter DONE in cycle 1 with done = 1, div_zero = 1, hi/lo unchanged.
REQ-022 SHALL hold hi/lo stable from the done cycle until the next done cycle; they never change at any other time.
REQ-023 SHALL keep div_zero low except in a DONE cycle caused by REQ-021.

Reset
REQ-024 SHALL, when reset = 0 at a clock edge, enter IDLE and clear busy, done, div_zero, hi, lo and the iteration counter to 0.
REQ-025 SHALL abandon any in-progress operation on reset with no done pulse; reset overrides a simultaneous start.
REQ-026 SHALL accept start in the first cycle after reset deasserts.

Structure
REQ-027 SHALL take the op encoding enum and the state enum from shared package mult_div_pkg, alongside the CPU's other control encodings.
REQ-028 SHALL be one module without sub-modules; multiply and divide share the iteration counter and the 2*WIDTH-bit working register.

Verification
REQ-029 SHALL cover WIDTH=32 MULT a=FFFFFFFD, b=00000005 -> done in cycle 33, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-030 SHALL cover WIDTH=32 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; same operands via MULT -> hi=00000000, lo=00000001.
REQ-031 SHALL cover WIDTH=32 DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=0.
REQ-032 SHALL cover DIVU b=0 with hi=0000ABCD held -> done and div_zero in cycle 1, hi still 0000ABCD; start pulsed mid-RUN -> no effect on result or timing.
REQ-033 SHALL cover reset=0 in cycle 10 of a MULT -> no done pulse, all outputs 0 from the next cycle; a new MULT 7*6 started in the cycle after reset -> lo=0000002A.
REQ-034 SHALL cover WIDTH=8 DIV a=F9, b=02 -> done in cycle 9, lo=FD, hi=FF; back-to-back start in the DONE cycle -> next done 9 cycles later.
